// File: rtl/slave_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : slave_port_arbiter_if
// Purpose  : Request/ack bus between a crossbar master and a slave port.
// Revision : 1.0 - initial release
// ============================================================================
interface slave_port_arbiter_if #(
  parameter int N = 32
);
  logic         req;
  logic [N-1:0] addr;
  logic         cmd;
  logic [N-1:0] wdata;
  logic         ack;
  logic [N-1:0] rdata;

  modport master (output req, addr, cmd, wdata, input  ack, rdata);
  modport slave  (input  req, addr, cmd, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/slave_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : slave_port_arbiter
// Purpose  : Two-master round-robin arbiter for one crossbar slave port.
// Revision : 1.0 - initial release
// ============================================================================
module slave_port_arbiter #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  slave_port_arbiter_if.slave  master_1,
  slave_port_arbiter_if.slave  master_2,
  slave_port_arbiter_if.master slave
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_1 = 2'd1,
    GRANT_2 = 2'd2
  } state_t;

  localparam logic         c_OWNER_M1 = 1'b0;
  localparam logic         c_OWNER_M2 = 1'b1;
  localparam logic [N-1:0] c_ZERO     = '0;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   rd_pending_q, rd_pending_d;
  logic   rd_owner_q, rd_owner_d;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    rd_pending_d   = 1'b0;
    rd_owner_d     = rd_owner_q;
    slave.req      = 1'b0;
    slave.addr     = c_ZERO;
    slave.cmd      = 1'b0;
    slave.wdata    = c_ZERO;
    master_1.ack   = 1'b0;
    master_2.ack   = 1'b0;
    master_1.rdata = c_ZERO;
    master_2.rdata = c_ZERO;

    case (state_q)
      IDLE: begin
        if (master_1.req && (!master_2.req || last_grant_q == c_OWNER_M2)) begin
          state_d = GRANT_1;
        end else if (master_2.req) begin
          state_d = GRANT_2;
        end
      end
      GRANT_1: begin
        slave.req    = master_1.req;
        slave.addr   = master_1.addr;
        slave.cmd    = master_1.cmd;
        slave.wdata  = master_1.wdata;
        master_1.ack = slave.ack & master_1.req;
        // A dropped request abandons the grant without an ack.
        if (!master_1.req) begin
          state_d = IDLE;
        end else if (slave.ack) begin
          state_d      = IDLE;
          last_grant_d = c_OWNER_M1;
          if (!master_1.cmd) begin
            rd_pending_d = 1'b1;
            rd_owner_d   = c_OWNER_M1;
          end
        end
      end
      GRANT_2: begin
        slave.req    = master_2.req;
        slave.addr   = master_2.addr;
        slave.cmd    = master_2.cmd;
        slave.wdata  = master_2.wdata;
        master_2.ack = slave.ack & master_2.req;
        if (!master_2.req) begin
          state_d = IDLE;
        end else if (slave.ack) begin
          state_d      = IDLE;
          last_grant_d = c_OWNER_M2;
          if (!master_2.cmd) begin
            rd_pending_d = 1'b1;
            rd_owner_d   = c_OWNER_M2;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data lands during the bubble after the ack, so it never overlaps a grant.
    if (rd_pending_q) begin
      if (rd_owner_q == c_OWNER_M1) begin
        master_1.rdata = slave.rdata;
      end else begin
        master_2.rdata = slave.rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= c_OWNER_M2;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= c_OWNER_M1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end
endmodule
`default_nettype wire
